// File: rtl/instr_register_pkg.sv
// Shared types and default sizing for the instruction register pipeline.
package instr_register_pkg;

  localparam int DEF_OP_W  = 32;
  localparam int DEF_DEPTH = 32;

  // Encodings 8..15 are undefined and produce a zero result.
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational ALU for stage 2: operands sign-extended to 2*OP_W, divide-by-zero flagged.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_W = DEF_OP_W
) (
  input  opcode_t                  opcode,
  input  logic signed [OP_W-1:0]   operand_a,
  input  logic signed [OP_W-1:0]   operand_b,
  output logic signed [2*OP_W-1:0] result,
  output logic                     div_err
);

  logic signed [2*OP_W-1:0] w_a;
  logic signed [2*OP_W-1:0] w_b;

  // Widening first makes most-negative / -1 exact and keeps the product full width.
  assign w_a = {{OP_W{operand_a[OP_W-1]}}, operand_a};
  assign w_b = {{OP_W{operand_b[OP_W-1]}}, operand_b};

  always_comb begin
    result  = '0;
    div_err = 1'b0;
    case (opcode)
      ZERO:  result = '0;
      PASSA: result = w_a;
      PASSB: result = w_b;
      ADD:   result = w_a + w_b;
      SUB:   result = w_a - w_b;
      MULT:  result = w_a * w_b;
      DIV: begin
        if (w_b == '0) div_err = 1'b1;
        else           result  = w_a / w_b;
      end
      MOD: begin
        if (w_b == '0) div_err = 1'b1;
        else           result  = w_a % w_b;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_pipe.sv
// DEPTH-slot instruction register with a 2-stage registered write pipeline and registered reads.
// Optional INSTR_REG_AUTO_WPTR_EN: write slot comes from an internal wrapping counter.
module instr_register_pipe
  import instr_register_pkg::*;
#(
  parameter  int OP_W  = DEF_OP_W,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_en,
  input  opcode_t                opcode,
  input  logic signed [OP_W-1:0] operand_a,
  input  logic signed [OP_W-1:0] operand_b,
  input  logic [PTR_W-1:0]       write_pointer,
  input  logic                   read_en,
  input  logic [PTR_W-1:0]       read_pointer,
  output logic [4+4*OP_W:0]      instruction_word,
  output logic                   rd_valid,
  output logic                   busy
);

  typedef struct packed {
    opcode_t                  opc;
    logic signed [OP_W-1:0]   op_a;
    logic signed [OP_W-1:0]   op_b;
    logic signed [2*OP_W-1:0] result;
    logic                     div_err;
  } instruction_t;

  localparam logic [PTR_W:0]   DEPTH_L = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

  // Strobes: load_en and read_en are single-cycle requests, always accepted (no ready, no stall).
  instruction_t             r_slots [DEPTH];
  logic                     r_s1_valid;
  opcode_t                  r_s1_opc;
  logic signed [OP_W-1:0]   r_s1_a;
  logic signed [OP_W-1:0]   r_s1_b;
  logic [PTR_W-1:0]         r_s1_ptr;
  instruction_t             r_rd_word;
  logic                     r_rd_valid;

  logic [PTR_W-1:0]         w_wptr;
  logic signed [2*OP_W-1:0] w_alu_result;
  logic                     w_alu_div_err;
  logic                     w_s2_wr;
  logic                     w_rd_in_range;

`ifdef INSTR_REG_AUTO_WPTR_EN
  logic [PTR_W-1:0] r_auto_wptr;
  logic             w_unused_wptr;

  assign w_unused_wptr = ^write_pointer;
  assign w_wptr        = r_auto_wptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_auto_wptr <= '0;
    else if (load_en) r_auto_wptr <= (r_auto_wptr == LAST) ? '0 : r_auto_wptr + PTR_W'(1);
  end
`else
  assign w_wptr = write_pointer;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_opc   <= ZERO;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_ptr   <= '0;
    end else begin
      r_s1_valid <= load_en;
      if (load_en) begin
        r_s1_opc <= opcode;
        r_s1_a   <= operand_a;
        r_s1_b   <= operand_b;
        r_s1_ptr <= w_wptr;
      end
    end
  end

  instr_alu #(.OP_W(OP_W)) u_alu (
    .opcode    (r_s1_opc),
    .operand_a (r_s1_a),
    .operand_b (r_s1_b),
    .result    (w_alu_result),
    .div_err   (w_alu_div_err)
  );

  // Out-of-range destinations still advance the pipe but never touch storage.
  assign w_s2_wr       = r_s1_valid && ({1'b0, r_s1_ptr} < DEPTH_L);
  assign w_rd_in_range = {1'b0, read_pointer} < DEPTH_L;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
    end else if (w_s2_wr) begin
      r_slots[r_s1_ptr] <= {r_s1_opc, r_s1_a, r_s1_b, w_alu_result, w_alu_div_err};
    end
  end

  // Reads see storage before the same-edge write: no bypass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_word  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= read_en;
      if (read_en) r_rd_word <= w_rd_in_range ? r_slots[read_pointer] : '0;
    end
  end

  assign instruction_word = r_rd_word;
  assign rd_valid         = r_rd_valid;
  assign busy             = r_s1_valid;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Directed self-checking bench for instr_register_pipe at OP_W=32, DEPTH=20.
module tb_instr_register_pipe;
  import instr_register_pkg::*;

  localparam int OP_W   = 32;
  localparam int DEPTH  = 20;
  localparam int PTR_W  = 5;
  localparam int WORD_W = 4 + 4*OP_W + 1;

  logic                   clk;
  logic                   reset_n;
  logic                   load_en;
  opcode_t                opcode;
  logic signed [OP_W-1:0] operand_a;
  logic signed [OP_W-1:0] operand_b;
  logic [PTR_W-1:0]       write_pointer;
  logic                   read_en;
  logic [PTR_W-1:0]       read_pointer;
  logic [WORD_W-1:0]      instruction_word;
  logic                   rd_valid;
  logic                   busy;

  instr_register_pipe #(.OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_en          (load_en),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .write_pointer    (write_pointer),
    .read_en          (read_en),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .rd_valid         (rd_valid),
    .busy             (busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [WORD_W-1:0] exp_mem [DEPTH];
  logic [WORD_W-1:0] exp_q[$];

  function automatic logic [WORD_W-1:0] mk(input logic [3:0] opc, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] r,
                                           input logic e);
    return {opc, a, b, r, e};
  endfunction

  // scoreboard compare
  task automatic check(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // drivers (called at a negedge, return at the next negedge)
  task automatic idle(input int n);
    load_en = 1'b0;
    read_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                      input logic [PTR_W-1:0] ptr, input int slot, input logic [WORD_W-1:0] exp);
    load_en       = 1'b1;
    read_en       = 1'b0;
    opcode        = opcode_t'(opc);
    operand_a     = a;
    operand_b     = b;
    write_pointer = ptr;
    if (slot >= 0) exp_mem[slot] = exp;
    @(negedge clk);
  endtask

  task automatic rd(input logic [PTR_W-1:0] ptr, input string tag);
    load_en      = 1'b0;
    read_en      = 1'b1;
    read_pointer = ptr;
    exp_q.push_back((int'(ptr) < DEPTH) ? exp_mem[int'(ptr)] : '0);
    @(negedge clk);
    read_en = 1'b0;
    check($sformatf("%s_valid", tag), WORD_W'(rd_valid), WORD_W'(1));
    check(tag, instruction_word, exp_q.pop_front());
  endtask

  initial begin
    reset_n = 1'b0; load_en = 1'b0; read_en = 1'b0; opcode = ZERO;
    operand_a = '0; operand_b = '0; write_pointer = '0; read_pointer = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    repeat (2) @(negedge clk);
    check("reset_word",  instruction_word, '0);
    check("reset_valid", WORD_W'(rd_valid), '0);
    check("reset_busy",  WORD_W'(busy), '0);
    reset_n = 1'b1;
    idle(1);

`ifndef INSTR_REG_AUTO_WPTR_EN
    // reset lands between stage 1 and stage 2: the write must vanish
    load_en = 1'b1; opcode = ADD; operand_a = 5; operand_b = 3; write_pointer = 2;
    @(negedge clk);
    load_en = 1'b0;
    check("midload_busy_before", WORD_W'(busy), WORD_W'(1));
    reset_n = 1'b0;
    #1;
    check("midload_busy_reset", WORD_W'(busy), '0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    check("midload_busy_after", WORD_W'(busy), '0);
    rd(2, "midload_slot2");

    // opcode sweep a=-7 b=2
    load(ZERO,  -32'sd7, 32'sd2, 0, 0, mk(ZERO,  -32'sd7, 32'sd2, 64'sd0,   1'b0));
    load(PASSA, -32'sd7, 32'sd2, 1, 1, mk(PASSA, -32'sd7, 32'sd2, -64'sd7,  1'b0));
    load(PASSB, -32'sd7, 32'sd2, 2, 2, mk(PASSB, -32'sd7, 32'sd2, 64'sd2,   1'b0));
    load(ADD,   -32'sd7, 32'sd2, 3, 3, mk(ADD,   -32'sd7, 32'sd2, -64'sd5,  1'b0));
    load(SUB,   -32'sd7, 32'sd2, 4, 4, mk(SUB,   -32'sd7, 32'sd2, -64'sd9,  1'b0));
    load(MULT,  -32'sd7, 32'sd2, 5, 5, mk(MULT,  -32'sd7, 32'sd2, -64'sd14, 1'b0));
    load(DIV,   -32'sd7, 32'sd2, 6, 6, mk(DIV,   -32'sd7, 32'sd2, -64'sd3,  1'b0));
    load(MOD,   -32'sd7, 32'sd2, 7, 7, mk(MOD,   -32'sd7, 32'sd2, -64'sd1,  1'b0));
    idle(2);
    for (int i = 0; i < 8; i++) rd(PTR_W'(i), $sformatf("sweep_slot%0d", i));

    // divide edge cases, undefined opcode, same-slot back-to-back writes
    load(DIV, 32'd10, 32'd0, 4, 4, mk(DIV, 32'd10, 32'd0, 64'd0, 1'b1));
    load(MOD, 32'h8000_0000, 32'hFFFF_FFFF, 5, 5, mk(MOD, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 1'b0));
    load(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6, 6,
         mk(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0));
    load(4'd9, 32'd5, 32'd3, 8, 8, mk(4'd9, 32'd5, 32'd3, 64'd0, 1'b0));
    load(ADD, 32'd1, 32'd2, 10, 10, mk(ADD, 32'd1, 32'd2, 64'd3, 1'b0));
    load(ADD, 32'd4, 32'd4, 10, 10, mk(ADD, 32'd4, 32'd4, 64'd8, 1'b0));
    idle(2);
    rd(4,  "div_by_zero");
    rd(5,  "mod_minneg");
    rd(6,  "div_minneg");
    rd(8,  "undef_opc");
    rd(10, "same_slot_later_wins");
    idle(1);
    check("valid_drops", WORD_W'(rd_valid), '0);
    check("word_holds",  instruction_word, exp_mem[10]);

    // read/write hazard on slot 3: old, old, new
    load_en = 1'b1; opcode = PASSA; operand_a = 9; operand_b = 0; write_pointer = 3;
    read_en = 1'b1; read_pointer = 3;
    @(negedge clk);
    load_en = 1'b0;
    check("hazard_n_valid", WORD_W'(rd_valid), WORD_W'(1));
    check("hazard_n",       instruction_word, mk(ADD, -32'sd7, 32'sd2, -64'sd5, 1'b0));
    @(negedge clk);
    check("hazard_n1_valid", WORD_W'(rd_valid), WORD_W'(1));
    check("hazard_n1",       instruction_word, mk(ADD, -32'sd7, 32'sd2, -64'sd5, 1'b0));
    exp_mem[3] = mk(PASSA, 32'd9, 32'd0, 64'd9, 1'b0);
    @(negedge clk);
    check("hazard_n2_valid", WORD_W'(rd_valid), WORD_W'(1));
    check("hazard_n2",       instruction_word, exp_mem[3]);
    idle(1);

    // out-of-range pointers
    load(PASSA, 32'd123, 32'd0, 25, -1, '0);
    idle(2);
    rd(25, "oob_read");
    for (int i = 0; i < DEPTH; i++) rd(PTR_W'(i), $sformatf("oob_slot%0d", i));
`else
    // auto pointer: 22 loads with write_pointer held at 7
    for (int k = 1; k <= 22; k++)
      load(PASSA, 32'(k), 32'd0, 7, (k - 1) % DEPTH, mk(PASSA, 32'(k), 32'd0, 64'(k), 1'b0));
    idle(2);
    rd(0, "auto_slot0");
    check("auto_slot0_is_load21", instruction_word, mk(PASSA, 32'd21, 32'd0, 64'd21, 1'b0));
    rd(1, "auto_slot1");
    check("auto_slot1_is_load22", instruction_word, mk(PASSA, 32'd22, 32'd0, 64'd22, 1'b0));
    rd(7, "auto_slot7");
    check("auto_slot7_is_load8", instruction_word, mk(PASSA, 32'd8, 32'd0, 64'd8, 1'b0));
    for (int i = 2; i < DEPTH; i++) rd(PTR_W'(i), $sformatf("auto_slot%0d", i));
`endif

    idle(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
